ifu_fetch_ctrl: RTL

- Front-end fetch controller sitting directly upstream of the instruction buffer.
- Generates the fetch PC and issues 8-byte-aligned requests to the I-cache, one outstanding at a time.
- Splits each 64-bit response into two instruction slots (inst0 = lower word, inst1 = upper word) and presents them to the instruction buffer.
- Honours the buffer's pause (full) request and backend redirects/flushes, discarding stale responses.

---
 rtl/ifu_fetch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: one outstanding 8-byte I-cache request, splits each response into two slots.
// Optional predecode flags are built only when IFU_PREDECODE_EN is defined.
module ifu_fetch_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 'hBFC0_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            pause_req,
  output logic            icache_req_valid,
  input  logic            icache_req_ready,
  output logic [PC_W-1:0] icache_req_addr,
  input  logic            icache_resp_valid,
  input  logic [63:0]     icache_resp_data,
  output logic            inst0_valid,
  output logic            inst1_valid,
  output logic [PC_W-1:0] inst0_pc,
  output logic [PC_W-1:0] inst1_pc,
  output logic [31:0]     inst0_data,
  output logic [31:0]     inst1_data,
  output logic            inst0_isJ,
  output logic            inst0_isBr,
  output logic            inst1_isJ,
  output logic            inst1_isBr
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic [2:0]      state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_base, pc_seq;
  logic [63:0]     hold_data;
  logic [PC_W-1:0] hold_base;
  logic            hold_v0, hold_v1;
  logic            capture, hold_clr;
  logic            slot_v0, slot_v1;
  logic [PC_W-1:0] slot_base;
  logic [63:0]     slot_data;

  assign pc_base         = {pc[PC_W-1:3], 3'b000};
  assign pc_seq          = pc_base + PC_W'(8);
  assign icache_req_addr = pc_base;

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    capture          = 1'b0;
    hold_clr         = 1'b0;
    icache_req_valid = 1'b0;
    slot_v0          = 1'b0;
    slot_v1          = 1'b0;
    slot_base        = pc_base;
    slot_data        = icache_resp_data;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        icache_req_valid = ~redirect_valid;
        if (icache_req_ready && !redirect_valid) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (icache_resp_valid) begin
          pc_nxt = pc_seq;
          if (pause_req) begin
            capture   = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            slot_v0   = ~pc[2];
            slot_v1   = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_HOLD: begin
        slot_base = hold_base;
        slot_data = hold_data;
        if (!pause_req) begin
          slot_v0   = hold_v0;
          slot_v1   = hold_v1;
          hold_clr  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_DROP: if (icache_resp_valid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
    // Redirect overrides everything; a response still in flight must be swallowed in S_DROP.
    if (redirect_valid) begin
      pc_nxt   = redirect_pc & ~(PC_W'(3));
      slot_v0  = 1'b0;
      slot_v1  = 1'b0;
      capture  = 1'b0;
      hold_clr = 1'b1;
      if ((state == S_WAIT || state == S_DROP) && !icache_resp_valid) state_nxt = S_DROP;
      else                                                            state_nxt = S_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      hold_data <= '0;
      hold_base <= '0;
      hold_v0   <= 1'b0;
      hold_v1   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        hold_data <= icache_resp_data;
        hold_base <= pc_base;
        hold_v0   <= ~pc[2];
        hold_v1   <= 1'b1;
      end else if (hold_clr) begin
        hold_v0 <= 1'b0;
        hold_v1 <= 1'b0;
      end
    end
  end

  assign inst0_valid = slot_v0 & ~pause_req;
  assign inst1_valid = slot_v1 & ~pause_req;
  assign inst0_pc    = slot_base;
  assign inst1_pc    = slot_base | PC_W'(4);
  assign inst0_data  = slot_data[31:0];
  assign inst1_data  = slot_data[63:32];

`ifdef IFU_PREDECODE_EN
  function automatic logic dec_j(input logic [31:0] w);
    return (w[31:26] == 6'h02) || (w[31:26] == 6'h03) ||
           (w[31:26] == 6'h00 && (w[5:0] == 6'h08 || w[5:0] == 6'h09));
  endfunction

  // 0x04-0x07 and 0x14-0x17 share their low two opcode bits as don't-cares.
  function automatic logic dec_br(input logic [31:0] w);
    return (w[31:28] == 4'b0001) || (w[31:26] == 6'h01) || (w[31:28] == 4'b0101);
  endfunction

  assign inst0_isJ  = inst0_valid & dec_j(inst0_data);
  assign inst0_isBr = inst0_valid & dec_br(inst0_data);
  assign inst1_isJ  = inst1_valid & dec_j(inst1_data);
  assign inst1_isBr = inst1_valid & dec_br(inst1_data);
`else
  assign inst0_isJ  = 1'b0;
  assign inst0_isBr = 1'b0;
  assign inst1_isJ  = 1'b0;
  assign inst1_isBr = 1'b0;
`endif

endmodule
